// File: rtl/loteria_apostador_pkg.sv
// Shared types and constants for the lottery bettor and the checker it feeds.
package loteria_apostador_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIGITO = 3'd1,
    ESPERA = 3'd2,
    ULTIMO = 3'd3,
    FECHA  = 3'd4,
    PAUSA  = 3'd5,
    FIM    = 3'd6
  } estado_t;

  // Checker-side states, kept here so both ends of the link agree on them.
  typedef enum logic [1:0] {
    CK_ESPERA  = 2'd0,
    CK_COLETA  = 2'd1,
    CK_CONFERE = 2'd2
  } estado_checker_t;

  localparam int         MAX_JOGOS_DEFAULT = 5;
  localparam int         NUM_DIGITOS       = 5;
  localparam logic [3:0] BCD_LIMITE        = 4'd9;

  // digit0 is the most significant nibble of the bet
  function automatic logic [3:0] digito(input logic [19:0] a, input logic [2:0] i);
    logic [3:0] d;
    case (i)
      3'd0:    d = a[19:16];
      3'd1:    d = a[15:12];
      3'd2:    d = a[11:8];
      3'd3:    d = a[7:4];
      default: d = a[3:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/loteria_bcd_check.sv
// Flags a 20-bit bet whose five nibbles are not all valid BCD digits.
`default_nettype none
module loteria_bcd_check
  import loteria_apostador_pkg::*;
(
  input  logic [19:0] aposta,
  output logic        invalido
);

  logic [NUM_DIGITOS-1:0] fora;

  for (genvar k = 0; k < NUM_DIGITOS; k++) begin : g_digito
    assign fora[k] = (aposta[4*k +: 4] > BCD_LIMITE);
  end

  assign invalido = |fora;

endmodule
`default_nettype wire

// File: rtl/loteria_apostador.sv
// Lottery bettor: accepts a five-digit BCD bet and plays it out digit by digit
// to the checker, counting games and closing the session after MAX_JOGOS.
`default_nettype none
module loteria_apostador
  import loteria_apostador_pkg::*;
#(
  parameter int MAX_JOGOS = MAX_JOGOS_DEFAULT,
  parameter int GAP       = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] aposta,
  input  logic        aposta_valid,
  output logic        aposta_ready,
  output logic [3:0]  numero,
  output logic        insere,
  output logic        fim_jogo,
  output logic        fim,
  output logic        ocupado,
  output logic [2:0]  jogos,
  output logic        erro
);

  localparam logic [1:0] GAP_CARGA = 2'(GAP - 1);
  // The last digit's wait ends in ULTIMO, so its ESPERA is one cycle shorter.
  localparam logic [1:0] GAP_ULT   = 2'((GAP > 1) ? (GAP - 2) : 0);

  estado_t     estado, estado_prox;
  logic [19:0] aposta_r;
  logic [1:0]  idx;
  logic [1:0]  gap_cnt;
  logic [2:0]  jogos_r;
  logic        erro_r;
  logic [3:0]  numero_hold;
  logic [3:0]  numero_c;
  logic        invalido;

  loteria_bcd_check u_bcd_check (
    .aposta   (aposta),
    .invalido (invalido)
  );

  always_comb begin
    estado_prox = estado;
    numero_c    = numero_hold;
    case (estado)
      IDLE: begin
        if (aposta_valid && !invalido) estado_prox = DIGITO;
      end
      DIGITO: begin
        numero_c = digito(aposta_r, {1'b0, idx});
        if (idx == 2'd3 && GAP == 1) estado_prox = ULTIMO;
        else                         estado_prox = ESPERA;
      end
      ESPERA: begin
        numero_c = digito(aposta_r, {1'b0, idx});
        if (gap_cnt == 2'd0) estado_prox = (idx == 2'd3) ? ULTIMO : DIGITO;
      end
      ULTIMO: begin
        numero_c    = digito(aposta_r, 3'd4);
        estado_prox = FECHA;
      end
      FECHA: begin
        numero_c    = digito(aposta_r, 3'd4);
        estado_prox = PAUSA;
      end
      PAUSA: begin
        numero_c    = digito(aposta_r, 3'd4);
        estado_prox = (jogos_r == 3'(MAX_JOGOS)) ? FIM : IDLE;
      end
      FIM:     estado_prox = IDLE;
      default: estado_prox = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= IDLE;
      aposta_r    <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      jogos_r     <= '0;
      erro_r      <= 1'b0;
      numero_hold <= '0;
    end else begin
      estado      <= estado_prox;
      numero_hold <= numero_c;
      // Never repeat erro on consecutive cycles even if a bad bet is held.
      erro_r      <= (estado == IDLE) && aposta_valid && invalido && !erro_r;
      case (estado)
        IDLE: begin
          if (aposta_valid && !invalido) begin
            aposta_r <= aposta;
            idx      <= '0;
          end
        end
        DIGITO: gap_cnt <= (idx == 2'd3) ? GAP_ULT : GAP_CARGA;
        ESPERA: begin
          if (gap_cnt != 2'd0)   gap_cnt <= gap_cnt - 2'd1;
          else if (idx != 2'd3)  idx     <= idx + 2'd1;
        end
        FECHA: begin
          if (jogos_r != 3'd7) jogos_r <= jogos_r + 3'd1;
        end
        FIM:     jogos_r <= '0;
        default: ;
      endcase
    end
  end

  assign aposta_ready = (estado == IDLE);
  assign ocupado      = (estado != IDLE);
  assign numero       = numero_c;
  assign insere       = (estado == DIGITO);
  assign fim_jogo     = (estado == FECHA);
  assign fim          = (estado == FIM);
  assign erro         = erro_r;
  assign jogos        = jogos_r;

endmodule
`default_nettype wire

// File: tb/tb_loteria_apostador.sv
// Self-checking bench: table-driven bets plus directed reset/back-to-back
// sequences, with strobes checked against a cycle-stamped scoreboard.
`default_nettype none
module tb_loteria_apostador;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] aposta = '0;
  logic        aposta_valid = 1'b0;
  logic        aposta_ready;
  logic [3:0]  numero;
  logic        insere, fim_jogo, fim, ocupado, erro;
  logic [2:0]  jogos;

  loteria_apostador #(.MAX_JOGOS(5), .GAP(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .aposta       (aposta),
    .aposta_valid (aposta_valid),
    .aposta_ready (aposta_ready),
    .numero       (numero),
    .insere       (insere),
    .fim_jogo     (fim_jogo),
    .fim          (fim),
    .ocupado      (ocupado),
    .jogos        (jogos),
    .erro         (erro)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [19:0] aposta;
    logic        rejeita;
    logic [3:0]  d0, d1, d2, d3, d4;
  } vetor_t;

  // tipo: 0 insere, 1 fim_jogo, 2 fim, 3 erro
  typedef struct packed {
    logic [1:0]  tipo;
    logic        usa_num;
    logic [3:0]  numero;
    logic [31:0] ciclo;
  } evento_t;

  int      ciclo = 0;
  int      nchk  = 0;
  int      nfail = 0;
  int      modelo = 0;
  evento_t fila[$];

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic confere(input string nome, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, got, exp, ciclo);
    end
  endtask

  task automatic ev(input logic [1:0] t, input logic u, input logic [3:0] n, input int c);
    evento_t e;
    e.tipo = t; e.usa_num = u; e.numero = n; e.ciclo = 32'(c);
    fila.push_back(e);
  endtask

  task automatic empurra(input vetor_t v, input int c0);
    if (v.rejeita) begin
      ev(2'd3, 1'b0, 4'd0, c0 + 1);
    end else begin
      ev(2'd0, 1'b1, v.d0, c0 + 1);
      ev(2'd0, 1'b1, v.d1, c0 + 3);
      ev(2'd0, 1'b1, v.d2, c0 + 5);
      ev(2'd0, 1'b1, v.d3, c0 + 7);
      ev(2'd1, 1'b1, v.d4, c0 + 9);
      modelo++;
      if (modelo == 5) begin
        ev(2'd2, 1'b0, 4'd0, c0 + 11);
        modelo = 0;
      end
    end
  endtask

  task automatic oferece(input vetor_t v, output int c0);
    int t = 0;
    aposta = v.aposta;
    aposta_valid = 1'b1;
    while (!aposta_ready && t < 40) begin @(negedge clock); t++; end
    confere("ready_timeout", 32'(t >= 40), 32'd0);
    c0 = ciclo;
    empurra(v, c0);
    @(negedge clock);
    aposta_valid = 1'b0;
  endtask

  task automatic espera_ocioso();
    int t = 0;
    while (ocupado && t < 50) begin @(negedge clock); t++; end
    confere("idle_timeout", 32'(t >= 50), 32'd0);
    confere("jogos", 32'(jogos), 32'(modelo));
  endtask

  task automatic confere_reset(input string tag);
    confere({tag, "_numero"},   32'(numero),       32'd0);
    confere({tag, "_insere"},   32'(insere),       32'd0);
    confere({tag, "_fim_jogo"}, 32'(fim_jogo),     32'd0);
    confere({tag, "_fim"},      32'(fim),          32'd0);
    confere({tag, "_erro"},     32'(erro),         32'd0);
    confere({tag, "_jogos"},    32'(jogos),        32'd0);
    confere({tag, "_ocupado"},  32'(ocupado),      32'd0);
    confere({tag, "_ready"},    32'(aposta_ready), 32'd1);
  endtask

  // Strobe monitor: every strobe must match the next scheduled event.
  always @(negedge clock) begin
    if (!reset) begin
      int n;
      logic [1:0] k;
      evento_t e;
      n = int'(insere) + int'(fim_jogo) + int'(fim) + int'(erro);
      if (n > 1) begin
        nchk++; nfail++;
        $display("FAIL strobe_overlap: %0d strobes high at cycle %0d", n, ciclo);
      end
      if (n >= 1) begin
        k = insere ? 2'd0 : fim_jogo ? 2'd1 : fim ? 2'd2 : 2'd3;
        nchk++;
        if (fila.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_strobe: tipo %0d numero %0h at cycle %0d, none expected", k, numero, ciclo);
        end else begin
          e = fila.pop_front();
          if (e.tipo != k || e.ciclo != 32'(ciclo) || (e.usa_num && e.numero != numero)) begin
            nfail++;
            $display("FAIL strobe: got tipo %0d numero %0h cycle %0d, expected tipo %0d numero %0h cycle %0d",
                     k, numero, ciclo, e.tipo, e.numero, e.ciclo);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vetor_t tab[4];
    vetor_t v534, v12345, v70615;
    int c0;
    int cb[5];
    int t;

    v534   = '{20'h53820, 1'b0, 4'd5, 4'd3, 4'd8, 4'd2, 4'd0};
    v12345 = '{20'h12345, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    v70615 = '{20'h70615, 1'b0, 4'd7, 4'd0, 4'd6, 4'd1, 4'd5};
    tab[0] = v12345;
    tab[1] = '{20'h5A820, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    tab[2] = '{20'h99999, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    tab[3] = '{20'hF0000, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    repeat (2) @(negedge clock);
    confere_reset("por");
    reset = 1'b0;

    // First bet right after reset release, then the table.
    oferece(v534, c0);
    espera_ocioso();
    for (int i = 0; i < 4; i++) begin
      oferece(tab[i], c0);
      espera_ocioso();
    end

    // Abort mid-game after the second digit.
    oferece(v534, c0);
    while (ciclo < c0 + 3) @(negedge clock);
    #1 reset = 1'b1;
    #1 confere_reset("mid");
    fila.delete();
    modelo = 0;
    @(negedge clock);
    reset = 1'b0;
    oferece(v12345, c0);
    espera_ocioso();

    // A bet offered while busy must be ignored.
    oferece(v70615, c0);
    @(negedge clock);
    aposta = 20'h11111;
    aposta_valid = 1'b1;
    @(negedge clock);
    aposta_valid = 1'b0;
    espera_ocioso();

    // Clean session, then five back-to-back games.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    modelo = 0;
    confere("queue_before_b2b", 32'(fila.size()), 32'd0);
    aposta = 20'h53820;
    aposta_valid = 1'b1;
    for (int g = 0; g < 5; g++) begin
      t = 0;
      while (!aposta_ready && t < 40) begin @(negedge clock); t++; end
      confere("b2b_timeout", 32'(t >= 40), 32'd0);
      cb[g] = ciclo;
      empurra(v534, cb[g]);
      @(negedge clock);
    end
    aposta_valid = 1'b0;
    for (int g = 0; g < 4; g++) confere("b2b_spacing", 32'(cb[g+1] - cb[g]), 32'd11);
    t = 0;
    while (ciclo < cb[4] + 11 && t < 40) begin @(negedge clock); t++; end
    confere("fim_pulse", 32'(fim), 32'd1);
    confere("ready_in_fim", 32'(aposta_ready), 32'd0);
    @(negedge clock);
    confere("ready_after_fim", 32'(aposta_ready), 32'd1);
    confere("jogos_after_fim", 32'(jogos), 32'd0);

    repeat (3) @(negedge clock);
    confere("queue_drained", 32'(fila.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/loteria_apostador.md
LOTERIA_APOSTADOR -- requirements
Module: loteria_apostador

Interface
REQ-001 Parameter MAX_JOGOS, default 5, is the number of games per session; the final game is followed by one fim pulse.
REQ-002 Parameter GAP, default 1, is the number of idle cycles inserted after each insere pulse (legal range 1..3).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 aposta  input  20  bet of five BCD digits; digit0 = [19:16] through digit4 = [3:0].
REQ-006 aposta_valid  input  1  bet offered.
REQ-007 aposta_ready  output  1  block can accept a bet; combinational from state.
REQ-008 numero  output  4  digit currently presented to the checker.
REQ-009 insere  output  1  one-cycle strobe qualifying numero for digits 0..3.
REQ-010 fim_jogo  output  1  one-cycle strobe qualifying numero (digit4) and closing the game.
REQ-011 fim  output  1  one-cycle strobe after game MAX_JOGOS.
REQ-012 ocupado  output  1  high whenever the state is not IDLE.
REQ-013 jogos  output  3  games completed in the current session.
REQ-014 erro  output  1  one-cycle strobe for a rejected bet.

Function
REQ-015 States SHALL be IDLE, DIGITO, ESPERA, ULTIMO, FECHA, PAUSA and FIM.
REQ-016 aposta_ready SHALL be 1 only in IDLE; a bet is accepted on any edge where aposta_valid and aposta_ready are both 1.
REQ-017 On accept, the bet SHALL be latched into an internal register, the digit index cleared and the state set to DIGITO.
- If any digit is greater than 9, the state stays IDLE, erro pulses on the next cycle, and jogos is unchanged.
REQ-018 DIGITO (1 cycle): numero = digit[idx], insere = 1; next state is ESPERA.
REQ-019 ESPERA (GAP cycles): insere = 0 and numero held; then idx increments and the state returns to DIGITO while idx < 3, otherwise goes to ULTIMO.
REQ-020 ULTIMO (1 cycle): numero = digit4, insere = 0 (setup); next state is FECHA.
REQ-021 FECHA (1 cycle): numero = digit4, fim_jogo = 1, and jogos increments with a saturating 3-bit add.
REQ-022 PAUSA (1 cycle): numero = digit4 held, fim_jogo = 0.
- Next state is FIM if jogos == MAX_JOGOS, otherwise IDLE.
REQ-023 FIM (1 cycle): fim = 1 and jogos cleared to 0; next state is IDLE.
REQ-024 Latency from the accept edge to the FECHA cycle SHALL be 4*(1+GAP)+1 cycles, which is 9 with GAP = 1.
REQ-025 insere, fim_jogo, fim and erro SHALL never be high in the same cycle, and each SHALL be high for at most one consecutive cycle.
REQ-026 In IDLE, numero SHALL hold its last driven value (0 after reset).
REQ-027 aposta_valid held high continuously SHALL start a new bet on the first cycle back in IDLE (back-to-back games), with no bubble beyond PAUSA/FIM.
REQ-028 Changes to aposta while not in IDLE SHALL have no effect.

Reset
REQ-029 Asserting reset at any time, including mid-game, SHALL immediately drive the following, with no fim_jogo or fim emitted for the aborted game:
- state = IDLE;
- numero = 0, insere = 0, fim_jogo = 0, fim = 0, erro = 0, jogos = 0;
- ocupado = 0 and aposta_ready = 1.
REQ-030 After reset deasserts, the first bet SHALL be accepted on the first rising edge with aposta_valid = 1.

Structure
REQ-031 A shared package SHALL hold:
- the state enumeration;
- the MAX_JOGOS default;
- the digit-count constant (5);
- the BCD-limit constant (9).
REQ-032 The checker-side state encoding SHALL be placed in the same package.
REQ-033 One sub-module, loteria_bcd_check, SHALL flag any digit greater than 9 in a 20-bit bet (combinational); all other logic stays in loteria_apostador.

Verification
REQ-034 Bet 0x53820 with GAP = 1 -> required response:
- insere on cycles 1, 3, 5, 7 after accept, with numero = 5, 3, 8, 2;
- fim_jogo on cycle 9 with numero = 0; jogos = 1.
REQ-035 Five back-to-back bets of 0x53820 -> five fim_jogo pulses, then fim on the cycle after the fifth PAUSA; jogos returns to 0 and aposta_ready rises the next cycle.
REQ-036 Bet 0x5A820 -> not accepted into DIGITO; erro = 1 for one cycle, insere stays 0 and jogos stays 0.
REQ-037 Reset asserted after the second insere -> all outputs 0 in the same cycle; no fim_jogo follows; the next bet 0x12345 produces a complete sequence 1, 2, 3, 4 then 5.
REQ-038 aposta_valid pulsed while ocupado = 1 -> ignored; only the in-flight game's digits appear on numero.
REQ-039 Connect to the checker with bet 0x53820 five times -> the checker's p1 count increments, confirming protocol compatibility.
